hazard_fwd_ctrl: RTL

Hazard and forwarding controller for the 5-stage pipeline. It tracks the destination registers of instructions in flight in EX, MEM and WB, and drives the 2-bit select lines of the EX-stage operand muxes (regfile / MEM result / WB result). It also generates load-use stalls, bubbles, pipeline freezes for memory wait states, and branch flushes. It sits beside the ID/EX boundary and is the only block that drives the operand-mux selects and the pipeline-register enables.

---
 rtl/hazard_fwd_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_fwd_ctrl
//  Purpose  : Hazard and forwarding controller for the 5-stage pipeline.
//             Tracks the destination registers of the instructions in EX,
//             MEM and WB. Drives the EX operand-mux selects. Generates
//             load-use stalls, bubbles, memory-wait freezes and branch
//             flushes.
//  Ports    : clock, reset (async, active-high)
//             id_*            - ID-stage instruction description
//             mem_busy        - data memory wait; freezes the pipeline
//             branch_flush    - taken branch in EX; kills ID and EX
//             fwd_sel_a/b     - registered operand selects
//                               (00 regfile, 01 EX/MEM, 10 MEM/WB)
//             stall_id        - hold PC and IF/ID (combinational)
//             bubble_ex       - load a NOP into ID/EX (combinational)
//             freeze          - hold all pipeline registers (combinational)
//             stall_count     - saturating count of stall cycles
//  Config   : define HAZARD_FWD_EN to enable forwarding. When it is left
//             undefined, the selects are tied to 00 and every RAW hazard
//             against EX or MEM stalls.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic [REG_ADDR_W-1:0]  id_dest,
  input  logic                   id_writes,
  input  logic                   id_is_load,
  input  logic                   mem_busy,
  input  logic                   branch_flush,
  output logic [1:0]             fwd_sel_a,
  output logic [1:0]             fwd_sel_b,
  output logic                   stall_id,
  output logic                   bubble_ex,
  output logic                   freeze,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [0:0] c_st_run    = 1'b0;
  localparam logic [0:0] c_st_freeze = 1'b1;

  localparam logic [STALL_CNT_W-1:0] c_cnt_max = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] c_cnt_one = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  // Tracking entries for the instructions in EX, MEM and WB.
  logic                  r_ex_valid,  r_mem_valid,  r_wb_valid;
  logic [REG_ADDR_W-1:0] r_ex_dest,   r_mem_dest,   r_wb_dest;
  logic                  r_ex_writes, r_mem_writes, r_wb_writes;
  logic                  r_ex_is_load, r_mem_is_load, r_wb_is_load;

  logic [0:0]            r_state;
  logic [STALL_CNT_W-1:0] r_stall_count;

  logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt;
  logic w_hazard;
  logic w_issue;

  // A producer matches a source only if it is a real writer of a
  // register other than r0 and the consumer actually reads that source.
  function automatic logic f_match(
    input logic                  valid,
    input logic                  writes,
    input logic [REG_ADDR_W-1:0] dest,
    input logic [REG_ADDR_W-1:0] src,
    input logic                  used
  );
    return used & valid & writes & (dest != '0) & (dest == src);
  endfunction

  assign w_ex_rs  = f_match(r_ex_valid,  r_ex_writes,  r_ex_dest,  id_rs, id_uses_rs);
  assign w_ex_rt  = f_match(r_ex_valid,  r_ex_writes,  r_ex_dest,  id_rt, id_uses_rt);
  assign w_mem_rs = f_match(r_mem_valid, r_mem_writes, r_mem_dest, id_rs, id_uses_rs);
  assign w_mem_rt = f_match(r_mem_valid, r_mem_writes, r_mem_dest, id_rt, id_uses_rt);

`ifdef HAZARD_FWD_EN
  // Only a load in EX cannot be forwarded in time.
  assign w_hazard = id_valid & r_ex_is_load & (w_ex_rs | w_ex_rt);
`else
  // Without forwarding, every producer still ahead of WB blocks the reader;
  // a WB producer writes the regfile before ID reads it.
  assign w_hazard = id_valid & (w_ex_rs | w_ex_rt | w_mem_rs | w_mem_rt);
`endif

  // A freeze masks stall/bubble. A flush kills the ID instruction, so it
  // overrides a simultaneous stall but still inserts the bubble.
  assign freeze    = mem_busy;
  assign stall_id  = ~mem_busy & w_hazard & ~branch_flush;
  assign bubble_ex = ~mem_busy & (w_hazard | branch_flush);
  assign w_issue   = id_valid & ~w_hazard & ~branch_flush;

  // The state only records whether the pipeline is waiting on memory.
  // Hold behaviour follows mem_busy directly, so the cycle in which
  // mem_busy drops already advances.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_st_run;
    end else begin
      r_state <= mem_busy ? c_st_freeze : c_st_run;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ex_valid    <= 1'b0;
      r_ex_dest     <= '0;
      r_ex_writes   <= 1'b0;
      r_ex_is_load  <= 1'b0;
      r_mem_valid   <= 1'b0;
      r_mem_dest    <= '0;
      r_mem_writes  <= 1'b0;
      r_mem_is_load <= 1'b0;
      r_wb_valid    <= 1'b0;
      r_wb_dest     <= '0;
      r_wb_writes   <= 1'b0;
      r_wb_is_load  <= 1'b0;
    end else if (!mem_busy) begin
      r_wb_valid    <= r_mem_valid;
      r_wb_dest     <= r_mem_dest;
      r_wb_writes   <= r_mem_writes;
      r_wb_is_load  <= r_mem_is_load;
      r_mem_valid   <= r_ex_valid;
      r_mem_dest    <= r_ex_dest;
      r_mem_writes  <= r_ex_writes;
      r_mem_is_load <= r_ex_is_load;
      r_ex_valid    <= w_issue;
      r_ex_dest     <= id_dest;
      r_ex_writes   <= id_writes;
      r_ex_is_load  <= id_is_load;
    end
  end

`ifdef HAZARD_FWD_EN
  logic [1:0] w_sel_a, w_sel_b;
  logic [1:0] r_fwd_sel_a, r_fwd_sel_b;

  // The younger producer (EX) wins over the older one (MEM).
  assign w_sel_a = w_ex_rs ? 2'b01 : (w_mem_rs ? 2'b10 : 2'b00);
  assign w_sel_b = w_ex_rt ? 2'b01 : (w_mem_rt ? 2'b10 : 2'b00);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fwd_sel_a <= 2'b00;
      r_fwd_sel_b <= 2'b00;
    end else if (!mem_busy) begin
      r_fwd_sel_a <= w_issue ? w_sel_a : 2'b00;
      r_fwd_sel_b <= w_issue ? w_sel_b : 2'b00;
    end
  end

  assign fwd_sel_a = r_fwd_sel_a;
  assign fwd_sel_b = r_fwd_sel_b;
`else
  assign fwd_sel_a = 2'b00;
  assign fwd_sel_b = 2'b00;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (stall_id && (r_stall_count != c_cnt_max)) begin
      r_stall_count <= r_stall_count + c_cnt_one;
    end
  end

  assign stall_count = r_stall_count;

  // The WB entry and the load flags beyond EX are tracked for
  // completeness, but no output depends on them.
  logic w_unused;
  assign w_unused = ^{r_state, r_ex_is_load, r_mem_is_load, r_wb_valid,
                      r_wb_dest, r_wb_writes, r_wb_is_load};

endmodule
`default_nettype wire
